// File: rtl/jet_pkg.sv
// Shared types and default parameters for the jet seed selector.
//   tower_t  : one calorimeter tower (eta, phi, et, e) at default widths
//   state_t  : control FSM states
//   max2     : elaboration-time helper for width arithmetic
package jet_pkg;
  localparam int N_TOWERS_DEF = 64;
  localparam int ETA_W_DEF    = 10;
  localparam int PHI_W_DEF    = 10;
  localparam int ET_W_DEF     = 10;
  localparam int E_W_DEF      = 10;
  localparam int PHI_BINS_DEF = 62;
  localparam int DR2_MAX_DEF  = 100;
  localparam int ET_MIN_DEF   = 0;

  typedef struct packed {
    logic [ETA_W_DEF-1:0] eta;
    logic [PHI_W_DEF-1:0] phi;
    logic [ET_W_DEF-1:0]  et;
    logic [E_W_DEF-1:0]   e;
  } tower_t;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPARE, S_EMIT} state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/jet_dr2.sv
// Combinational squared angular distance between two towers.
//   eta_a/phi_a, eta_b/phi_b : bin indices of the two towers
//   dr2                      : deta^2 + dphi^2, full width, phi wrapped on a ring
module jet_dr2 import jet_pkg::*; #(
  parameter  int ETA_W    = ETA_W_DEF,
  parameter  int PHI_W    = PHI_W_DEF,
  parameter  int PHI_BINS = PHI_BINS_DEF,
  localparam int MW       = max2(ETA_W, PHI_W),
  localparam int DW       = 2*MW + 1
) (
  input  logic [ETA_W-1:0] eta_a,
  input  logic [PHI_W-1:0] phi_a,
  input  logic [ETA_W-1:0] eta_b,
  input  logic [PHI_W-1:0] phi_b,
  output logic [DW-1:0]    dr2
);
  logic [MW-1:0] deta, dphi_raw, dphi;

  always_comb begin
    deta     = (eta_a > eta_b) ? MW'(eta_a - eta_b) : MW'(eta_b - eta_a);
    dphi_raw = (phi_a > phi_b) ? MW'(phi_a - phi_b) : MW'(phi_b - phi_a);
    // shorter way round the phi ring
    dphi     = (dphi_raw > MW'(PHI_BINS/2)) ? MW'(PHI_BINS) - dphi_raw : dphi_raw;
    // 2*MW+1 bits holds the sum of two MW-bit squares exactly
    dr2      = DW'(deta)*DW'(deta) + DW'(dphi)*DW'(dphi);
  end
endmodule

// File: rtl/jet_seed_selector.sv
// Jet seed selector: buffers one event of towers, suppresses every tower that
// has a harder (or equal-Et, lower-index) neighbour within DR2_MAX, then
// streams the survivors in index order.
//   in_*       : tower stream, valid/ready, in_last marks the final tower
//   out_*      : seed stream, valid/ready, out_last marks the final seed
//   done       : one-cycle pulse at event end
//   seed_count : seeds emitted by the last completed event
module jet_seed_selector import jet_pkg::*; #(
  parameter  int N_TOWERS = N_TOWERS_DEF,
  parameter  int ETA_W    = ETA_W_DEF,
  parameter  int PHI_W    = PHI_W_DEF,
  parameter  int ET_W     = ET_W_DEF,
  parameter  int E_W      = E_W_DEF,
  parameter  int PHI_BINS = PHI_BINS_DEF,
  parameter  int DR2_MAX  = DR2_MAX_DEF,
  parameter  int ET_MIN   = ET_MIN_DEF,
  localparam int CW       = $clog2(N_TOWERS+1),
  localparam int IW       = (N_TOWERS > 1) ? $clog2(N_TOWERS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [ETA_W-1:0] in_eta,
  input  logic [PHI_W-1:0] in_phi,
  input  logic [ET_W-1:0]  in_et,
  input  logic [E_W-1:0]   in_e,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [ETA_W-1:0] out_eta,
  output logic [PHI_W-1:0] out_phi,
  output logic [ET_W-1:0]  out_et,
  output logic [E_W-1:0]   out_e,
  output logic             done,
  output logic [CW-1:0]    seed_count
);
  localparam int DW = 2*max2(ETA_W, PHI_W) + 1;

  typedef struct packed {
    logic [ETA_W-1:0] eta;
    logic [PHI_W-1:0] phi;
    logic [ET_W-1:0]  et;
    logic [E_W-1:0]   e;
  } twr_t;

  twr_t                mem [N_TOWERS];
  logic [N_TOWERS-1:0] sup, sup_nxt, srch_vec;
  state_t              state, state_nxt;
  logic [CW-1:0]       n, cnt, srch_lo;
  logic [IW-1:0]       i, j, ptr, f_idx;
  logic [DW-1:0]       dr2;
  twr_t                ti, tj, to;
  logic                xfer, load_end, hit, j_last, last_pair, found;

  assign in_ready  = (state == S_IDLE) || (state == S_LOAD);
  assign xfer      = in_valid & in_ready;
  assign load_end  = xfer & (in_last | (n == CW'(N_TOWERS-1)));
  assign ti        = mem[i];
  assign tj        = mem[j];
  assign j_last    = (CW'(j) == n - CW'(1));
  assign last_pair = j_last && (CW'(i) == n - CW'(1));

  jet_dr2 #(.ETA_W(ETA_W), .PHI_W(PHI_W), .PHI_BINS(PHI_BINS)) u_dr2 (
    .eta_a(ti.eta), .phi_a(ti.phi), .eta_b(tj.eta), .phi_b(tj.phi), .dr2(dr2)
  );

  // j suppresses i: close enough and harder, ties broken toward lower index
  assign hit = (i != j) && (64'(dr2) < 64'(DR2_MAX)) &&
               ((tj.et > ti.et) || ((tj.et == ti.et) && (j < i)));

  always_comb begin
    sup_nxt = sup;
    if (state == S_COMPARE && hit) sup_nxt[i] = 1'b1;
  end

  // Lowest surviving index >= srch_lo. At the last compare pair it looks at
  // the flags including that pair, so the first seed (or the zero-seed case)
  // is known without an extra cycle.
  always_comb begin
    srch_vec = (state == S_EMIT) ? sup : sup_nxt;
    srch_lo  = (state == S_EMIT) ? CW'(ptr) + CW'(1) : '0;
    found    = 1'b0;
    f_idx    = '0;
    for (int k = N_TOWERS-1; k >= 0; k--) begin
      if (k >= int'(srch_lo) && k < int'(n) && !srch_vec[k]) begin
        found = 1'b1;
        f_idx = IW'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // A lone in_last tower taken in IDLE goes straight to COMPARE; any other
  // first transfer passes through LOAD.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (xfer) state_nxt = load_end ? S_COMPARE : S_LOAD;
      S_LOAD:    if (load_end) state_nxt = S_COMPARE;
      S_COMPARE: if (last_pair) state_nxt = found ? S_EMIT : S_IDLE;
      S_EMIT:    if (out_ready && !found) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  assign out_valid = (state == S_EMIT);
  assign out_last  = out_valid & ~found;
  assign to        = out_valid ? mem[ptr] : '0;
  assign out_eta   = to.eta;
  assign out_phi   = to.phi;
  assign out_et    = to.et;
  assign out_e     = to.e;

  // Tower storage carries no reset; n and the flags define what is live.
  always_ff @(posedge clk) begin
    if (xfer) mem[IW'(n)] <= '{eta: in_eta, phi: in_phi, et: in_et, e: in_e};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n <= '0; cnt <= '0; i <= '0; j <= '0; ptr <= '0;
      sup <= '0; done <= 1'b0; seed_count <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE, S_LOAD: if (xfer) begin
          sup[IW'(n)] <= (64'(in_et) < 64'(ET_MIN));
          n <= n + CW'(1);
          i <= '0;
          j <= '0;
        end
        S_COMPARE: begin
          sup <= sup_nxt;
          if (j_last) begin j <= '0; i <= i + IW'(1); end
          else        j <= j + IW'(1);
          if (last_pair) begin
            if (found) begin
              ptr <= f_idx;
              cnt <= '0;
            end else begin
              done <= 1'b1; seed_count <= '0; n <= '0; sup <= '0;
            end
          end
        end
        S_EMIT: if (out_ready) begin
          cnt <= cnt + CW'(1);
          if (found) ptr <= f_idx;
          else begin
            done <= 1'b1; seed_count <= cnt + CW'(1); n <= '0; sup <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_jet_seed_selector.sv
module tb_jet_seed_selector;
  import jet_pkg::*;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1, sel2 = 1'b0;
  logic [9:0] in_eta = '0, in_phi = '0, in_et = '0, in_e = '0;

  logic       v1, v2, r1, r2, ov1, ov2, ol1, ol2, d1, d2;
  logic [9:0] eta1, phi1, et1, e1, eta2, phi2, et2, e2;
  logic [6:0] sc1;
  logic [3:0] sc2;
  assign v1 = in_valid & ~sel2;
  assign v2 = in_valid & sel2;

  jet_seed_selector u_dut (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_last(in_last),
    .in_eta(in_eta), .in_phi(in_phi), .in_et(in_et), .in_e(in_e),
    .out_valid(ov1), .out_ready(out_ready), .out_last(ol1),
    .out_eta(eta1), .out_phi(phi1), .out_et(et1), .out_e(e1),
    .done(d1), .seed_count(sc1)
  );

  jet_seed_selector #(.N_TOWERS(8), .ET_MIN(100)) u_dut_min (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2), .in_last(in_last),
    .in_eta(in_eta), .in_phi(in_phi), .in_et(in_et), .in_e(in_e),
    .out_valid(ov2), .out_ready(out_ready), .out_last(ol2),
    .out_eta(eta2), .out_phi(phi2), .out_et(et2), .out_e(e2),
    .done(d2), .seed_count(sc2)
  );

  logic       m_in_ready, m_out_valid, m_out_last, m_done;
  logic [9:0] m_eta, m_phi, m_et, m_e;
  logic [6:0] m_cnt;
  assign m_in_ready  = sel2 ? r2  : r1;
  assign m_out_valid = sel2 ? ov2 : ov1;
  assign m_out_last  = sel2 ? ol2 : ol1;
  assign m_done      = sel2 ? d2  : d1;
  assign m_eta       = sel2 ? eta2 : eta1;
  assign m_phi       = sel2 ? phi2 : phi1;
  assign m_et        = sel2 ? et2 : et1;
  assign m_e         = sel2 ? e2  : e1;
  assign m_cnt       = sel2 ? {3'b000, sc2} : sc1;

  int nvec = 0, nerr = 0;
  int exq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic tower_t mk(input int eta, input int phi, input int et, input int e);
    tower_t t;
    t.eta = 10'(eta); t.phi = 10'(phi); t.et = 10'(et); t.e = 10'(e);
    return t;
  endfunction

  // Reference: a tower survives unless its Et is below the floor or some
  // other tower inside the radius outranks it (higher Et, or equal Et and
  // earlier arrival). Phi distance is the short way round a 62-bin ring.
  task automatic model(input tower_t tw[$], input int etmin);
    exq.delete();
    for (int a = 0; a < tw.size(); a++) begin
      bit keep;
      keep = (int'(tw[a].et) >= etmin);
      for (int b = 0; b < tw.size(); b++) begin
        int de, dp;
        if (b == a) continue;
        de = int'(tw[a].eta) - int'(tw[b].eta); if (de < 0) de = -de;
        dp = int'(tw[a].phi) - int'(tw[b].phi); if (dp < 0) dp = -dp;
        if (dp > 31) dp = 62 - dp;
        if (de*de + dp*dp < 100 &&
            (tw[b].et > tw[a].et || (tw[b].et == tw[a].et && b < a))) keep = 1'b0;
      end
      if (keep) exq.push_back(a);
    end
  endtask

  task automatic send_towers(input tower_t tw[$], input bit has_last);
    foreach (tw[k]) begin
      int w;
      in_valid = 1'b1;
      in_eta = tw[k].eta; in_phi = tw[k].phi; in_et = tw[k].et; in_e = tw[k].e;
      in_last = has_last && (k == tw.size()-1);
      w = 0;
      while (!m_in_ready && w < 100) begin @(posedge clk); #1; w++; end
      if (!m_in_ready) chk("in_ready_wait", {63'd0, m_in_ready}, 64'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic collect(input tower_t tw[$], input int stall);
    int c, got, st, n;
    tower_t t;
    n = tw.size(); c = 0; got = 0; st = stall;
    chk("in_ready_after_load", {63'd0, m_in_ready}, 64'd0);
    while (c < 20000) begin
      if (m_done) break;
      if (m_out_valid) begin
        if (got >= exq.size()) begin
          chk("extra_seed", {63'd0, m_out_valid}, 64'd0);
          break;
        end
        t = tw[exq[got]];
        if (st > 0) begin
          out_ready = 1'b0;
          chk("stall_hold", {24'd0, m_eta, m_phi, m_et, m_e}, {24'd0, t});
          st--;
        end else begin
          out_ready = 1'b1;
          chk("seed_fields", {24'd0, m_eta, m_phi, m_et, m_e}, {24'd0, t});
          chk("seed_last", {63'd0, m_out_last}, {63'd0, got == exq.size()-1});
          got++;
        end
      end
      @(posedge clk); #1; c++;
    end
    out_ready = 1'b1;
    chk("done_seen", {63'd0, m_done}, 64'd1);
    chk("done_latency", c, n*n + exq.size() + stall);
    chk("seed_count", {57'd0, m_cnt}, exq.size());
    chk("seed_total", got, exq.size());
    @(posedge clk); #1;
    chk("done_one_cycle", {63'd0, m_done}, 64'd0);
    chk("seed_count_held", {57'd0, m_cnt}, exq.size());
  endtask

  task automatic run_event(input tower_t tw[$], input bit has_last, input int stall);
    model(tw, sel2 ? 100 : 0);
    send_towers(tw, has_last);
    collect(tw, stall);
  endtask

  function automatic tower_t rnd_tower(input int et_hi);
    return mk($urandom_range(0, 15), $urandom_range(0, 61),
              $urandom_range(0, et_hi), $urandom_range(0, 1023));
  endfunction

  initial begin
    tower_t tw[$];
    logic   bad;

    // reset, with in_valid asserted to show reset wins
    in_valid = 1'b1; in_et = 10'd77; in_last = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, r1}, 64'd1);
    chk("rst_out_valid", {63'd0, ov1}, 64'd0);
    chk("rst_out_last", {63'd0, ol1}, 64'd0);
    chk("rst_done", {63'd0, d1}, 64'd0);
    chk("rst_seed_count", {57'd0, sc1}, 64'd0);
    chk("rst_out_fields", {24'd0, eta1, phi1, et1, e1}, 64'd0);
    in_valid = 1'b0; in_last = 1'b0; rst = 1'b0;
    @(posedge clk); #1;

    // two well separated towers: both seeds
    tw = '{mk(5, 10, 50, 1), mk(20, 10, 40, 2)};
    run_event(tw, 1'b1, 0);
    // phi wrap: dphi 3, lower Et tower suppressed
    tw = '{mk(5, 1, 30, 3), mk(5, 60, 40, 4)};
    run_event(tw, 1'b1, 0);
    // equal Et inside radius: lower index wins
    tw = '{mk(0, 0, 25, 5), mk(3, 4, 25, 6)};
    run_event(tw, 1'b1, 0);
    // zero-valued fields are real towers
    tw = '{mk(0, 0, 0, 0)};
    run_event(tw, 1'b1, 0);

    // full event without in_last
    tw.delete();
    for (int k = 0; k < 64; k++) tw.push_back(rnd_tower(1023));
    run_event(tw, 1'b0, 0);

    // backpressure during emission
    tw.delete();
    for (int k = 0; k < 6; k++) tw.push_back(rnd_tower(15));
    run_event(tw, 1'b1, 5);

    // randomized events
    for (int ev = 0; ev < 6; ev++) begin
      tw.delete();
      for (int k = 0; k < int'($urandom_range(1, 12)); k++) tw.push_back(rnd_tower(7));
      run_event(tw, 1'b1, 0);
    end

    // Et floor of 100: nothing qualifies, then a mixed event
    sel2 = 1'b1;
    tw.delete();
    for (int k = 0; k < 5; k++) tw.push_back(rnd_tower(99));
    run_event(tw, 1'b1, 0);
    tw.delete();
    for (int k = 0; k < 8; k++) tw.push_back(rnd_tower(200));
    run_event(tw, 1'b1, 0);
    sel2 = 1'b0;

    // abort mid-compare, then a clean single-tower event
    tw = '{mk(1, 1, 9, 1), mk(2, 2, 8, 2), mk(40, 30, 7, 3), mk(3, 3, 6, 4)};
    send_towers(tw, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    chk("abort_in_ready", {63'd0, r1}, 64'd1);
    bad = 1'b0;
    for (int k = 0; k < 30; k++) begin
      bad = bad | d1 | ov1;
      @(posedge clk); #1;
    end
    chk("abort_quiet", {63'd0, bad}, 64'd0);
    tw = '{mk(33, 44, 55, 66)};
    run_event(tw, 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
